draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Frame-level sequencer for the shared drawing resources: the tile ROM address bus and the tri-stated VGA write bus (x, y, RGB, draw enable). Each drawer, such as the map drawer or a sprite drawer, is one client. On each frame the scheduler launches the requesting clients one at a time, in fixed ascending index order. Client 0 is the map drawer, so it always paints first and later clients overdraw it. The scheduler guarantees that at most one client drives the shared buses at any time and inserts a turnaround cycle between owners.

## Interface
- N_CLIENTS, 4: number of drawer clients (2..8).
- TIMEOUT_CYCLES, 65535: maximum cycles a client may take between its draw pulse and done before it is abandoned (16-bit).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle pulse that begins a frame pass.
- client_req  in  N_CLIENTS  client i wants a slot this frame; sampled only on the accepted frame_start.
- client_active  in  N_CLIENTS  client i is currently driving the shared buses (its `active`).
- client_done  in  N_CLIENTS  client i finished its pass (single-cycle pulse).
- client_draw  out  N_CLIENTS  one-cycle start pulse to the granted client (its `draw`).
- grant  out  N_CLIENTS  one-hot current owner; all-zero when no owner.
- cur_client  out  $clog2(N_CLIENTS)  index of the current or last owner.
- busy  out  1  a frame pass is in progress.
- frame_done  out  1  one-cycle pulse when the pass completes.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.
- contention_err  out  1  sticky; set when more than one client_active bit is high.
- timeout_err  out  1  sticky; set when a client is abandoned.

## Operation
- States: IDLE, SCAN, LAUNCH, WAIT_DONE, GAP, FRAME_DONE.
- IDLE: if frame_start, latch pending <= client_req and go to SCAN. busy is 0 only in IDLE.
- SCAN: if pending == 0, go to FRAME_DONE. Otherwise sel <= lowest set bit of pending, then go to LAUNCH.
- LAUNCH: client_draw[sel] = 1 for this cycle only. grant[sel] = 1 from LAUNCH through WAIT_DONE. Clear the watchdog counter. Go to WAIT_DONE.
- WAIT_DONE: if client_done[sel], go to GAP. If the watchdog counter reaches TIMEOUT_CYCLES-1 without done, set timeout_err and go to GAP. client_done on a non-selected bit is ignored.
- GAP: grant = 0 for one turnaround cycle. Clear pending[sel]. Go to SCAN.
- FRAME_DONE: frame_done = 1, then go to IDLE.
- frame_start while not in IDLE: ignored for sequencing and pulses frame_overrun. A frame_start in the FRAME_DONE cycle is also dropped.
- contention_err is evaluated every cycle in every state. It is cleared only by reset.
- cur_client holds its value after the pass and resets to 0.

## Timing
- Reset: state IDLE, pending 0, and every output 0 (client_draw, grant, cur_client, busy, frame_done, frame_overrun, contention_err, timeout_err).
- All outputs are registered or decoded from state only; nothing is combinationally derived from inputs.
- frame_start sampled at edge k: SCAN during cycle k+1, client_draw high during cycle k+2.
- client_done sampled at edge m: GAP during m+1, SCAN m+2, next client_draw during m+3.
- Empty request mask: frame_done high during cycle k+2.
- Done arriving in the same cycle as LAUNCH is ignored; the client must pulse done at least one cycle after draw.
- Reset mid-pass: the pass is aborted immediately. No done or frame_done is issued, and grant drops on the next cycle.

## Configuration
- DRAW_SCHEDULER_WATCHDOG_EN defined: the 16-bit watchdog counter and the abandon path exist as described.
- Not defined: no counter exists, WAIT_DONE waits indefinitely for done, and timeout_err is tied to 0.

## Structure
- draw_sched_pkg: the state enum, the default N_CLIENTS, and the width of the watchdog counter.
- Sub-module draw_sched_pick: lowest-set-bit priority encoder from pending to an index plus a valid flag. It is reused by the SCAN state.

## Test plan
- N_CLIENTS=4, client_req=4'b0101, each client pulses done 10 cycles after draw: draw pulses go to client 0 then client 2, grant never overlaps, and frame_done appears 3 cycles after client 2's done.
- client_req=0 with frame_start at cycle 5: frame_done high at cycle 7, with no draw or grant activity.
- frame_start re-pulsed during WAIT_DONE: frame_overrun pulses once and the sequence is unchanged.
- client_active=4'b0011 for one cycle: contention_err rises the next cycle and stays high until reset.
- Watchdog enabled, TIMEOUT_CYCLES=16, client 1 never signals done: timeout_err set, client 1 abandoned, and client 3 launched 3 cycles later.
- reset asserted in WAIT_DONE: next cycle grant=0, busy=0, and all sticky flags are 0.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw scheduler: the sequencer state
// enum, the default client count and the watchdog counter width.
package draw_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_GAP,
        ST_FRAME_DONE
    } state_t;

    localparam int DEFAULT_N_CLIENTS = 4;
    localparam int WDOG_W            = 16;

endpackage

// File: rtl/draw_sched_pick.sv
// Lowest-set-bit priority encoder: turns the pending-client mask into the
// index of the next client to launch, plus a flag saying any bit was set.
module draw_sched_pick
    import draw_sched_pkg::*;
#(
    parameter int N     = DEFAULT_N_CLIENTS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = |pending;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Frame-level sequencer for the shared tile-ROM / VGA write buses. Launches
// requesting drawer clients one at a time in ascending index order, keeps a
// one-hot grant, and inserts a one-cycle turnaround between owners.
// Optional build macro: DRAW_SCHEDULER_WATCHDOG_EN adds a 16-bit watchdog
// that abandons a client that never signals done.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int N_CLIENTS      = DEFAULT_N_CLIENTS,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [N_CLIENTS-1:0]         client_req,
    input  logic [N_CLIENTS-1:0]         client_active,
    input  logic [N_CLIENTS-1:0]         client_done,
    output logic [N_CLIENTS-1:0]         client_draw,
    output logic [N_CLIENTS-1:0]         grant,
    output logic [$clog2(N_CLIENTS)-1:0] cur_client,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_overrun,
    output logic                         contention_err,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(N_CLIENTS);

    state_t               state_q, state_d;
    logic [N_CLIENTS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 frame_overrun_q, frame_overrun_d;
    logic                 contention_err_q, contention_err_d;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic [N_CLIENTS-1:0] sel_onehot;

`ifdef DRAW_SCHEDULER_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    draw_sched_pick #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending_q),
        .idx     (pick_idx),
        .valid   (pick_vld)
    );

    // Next-state logic: pass sequencing, error flags and watchdog
    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        sel_d            = sel_q;
        frame_overrun_d  = frame_start && (state_q != ST_IDLE);
        // x & (x-1) is non-zero exactly when two or more bits are set
        contention_err_d = contention_err_q |
                           ((client_active & (client_active - N_CLIENTS'(1))) != '0);
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
        wdog_d           = wdog_q;
        timeout_err_d    = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    pending_d = client_req;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!pick_vld) begin
                    state_d = ST_FRAME_DONE;
                end else begin
                    sel_d   = pick_idx;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
                wdog_d  = '0;
`endif
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (client_done[sel_q]) begin
                    state_d = ST_GAP;
                end
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            ST_GAP: begin
                pending_d[sel_q] = 1'b0;
                state_d          = ST_SCAN;
            end
            ST_FRAME_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pending_q        <= '0;
            sel_q            <= '0;
            frame_overrun_q  <= 1'b0;
            contention_err_q <= 1'b0;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
            wdog_q           <= '0;
            timeout_err_q    <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            sel_q            <= sel_d;
            frame_overrun_q  <= frame_overrun_d;
            contention_err_q <= contention_err_d;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
            wdog_q           <= wdog_d;
            timeout_err_q    <= timeout_err_d;
`endif
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        sel_onehot     = N_CLIENTS'(1) << sel_q;
        client_draw    = (state_q == ST_LAUNCH) ? sel_onehot : '0;
        grant          = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE)) ? sel_onehot : '0;
        cur_client     = sel_q;
        busy           = (state_q != ST_IDLE);
        frame_done     = (state_q == ST_FRAME_DONE);
        frame_overrun  = frame_overrun_q;
        contention_err = contention_err_q;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
        timeout_err    = timeout_err_q;
`else
        timeout_err    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler. A schedule-based model (queue of
// remaining clients plus absolute cycle numbers of the next draw/frame_done)
// predicts every output each cycle; directed scenarios pin absolute timings.
// Watchdog scenario runs only when DRAW_SCHEDULER_WATCHDOG_EN is defined.
module tb_draw_scheduler;

    localparam int N = 4;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
    localparam int TB_TO   = 16;
    localparam bit WDOG_EN = 1'b1;
`else
    localparam int TB_TO   = 65535;
    localparam bit WDOG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_start;
    logic [N-1:0] client_req;
    logic [N-1:0] client_active;
    logic [N-1:0] client_done;
    logic [N-1:0] client_draw;
    logic [N-1:0] grant;
    logic [1:0]   cur_client;
    logic         busy;
    logic         frame_done;
    logic         frame_overrun;
    logic         contention_err;
    logic         timeout_err;

    draw_scheduler #(
        .N_CLIENTS      (N),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .client_req     (client_req),
        .client_active  (client_active),
        .client_done    (client_done),
        .client_draw    (client_draw),
        .grant          (grant),
        .cur_client     (cur_client),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_overrun  (frame_overrun),
        .contention_err (contention_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // client behaviour: -1 random delay, 0 never done, k>0 fixed delay
    int dly_mode [N];
    int done_at  [N];

    // observation log
    int draw_cyc [N];
    int fd_cyc;
    int draws_seen;
    int grants_seen;
    int ovr_seen;

    // model: expectations for the current cycle
    int m_draw  = -1;
    int m_owner = -1;
    int m_cur   = 0;
    bit m_busy  = 0;
    bit m_fd    = 0;
    bit m_ovr   = 0;
    bit m_cont  = 0;
    bit m_tout  = 0;
    // model: future schedule
    int q[$];
    int fut_draw = -1;
    int fut_fd   = -1;
    int m_launch = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        return (idx >= 0) ? (N'(1) << idx) : '0;
    endfunction

    // Per-cycle compare, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        int n_draw, n_owner, n_cur;
        bit n_busy, n_fd, n_ovr, n_cont, n_tout, rel, to;
        if (cyc >= 1) begin
            chk("client_draw", 32'(client_draw), 32'(onehot(m_draw)));
            chk("grant", 32'(grant), 32'(onehot(m_owner)));
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            chk("cur_client", 32'(cur_client), 32'(m_cur));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
            chk("contention_err", 32'(contention_err), 32'(m_cont));
            chk("timeout_err", 32'(timeout_err), 32'(m_tout));
        end
        for (int i = 0; i < N; i++) if (client_draw[i] === 1'b1) begin
            draw_cyc[i] = cyc;
            draws_seen++;
        end
        if (grant !== '0) grants_seen++;
        if (frame_done === 1'b1) fd_cyc = cyc;
        if (frame_overrun === 1'b1) ovr_seen++;

        if (reset) begin
            q.delete();
            fut_draw = -1; fut_fd = -1; m_launch = -1;
            m_draw = -1; m_owner = -1; m_cur = 0;
            m_busy = 0; m_fd = 0; m_ovr = 0; m_cont = 0; m_tout = 0;
        end else begin
            rel = 0; to = 0;
            n_owner = m_owner;
            n_cur   = m_cur;
            if (m_owner >= 0 && m_draw < 0) begin
                if (client_done[m_owner]) rel = 1;
                else if (WDOG_EN && (cyc - m_launch) == TB_TO) begin
                    rel = 1; to = 1;
                end
            end
            n_cont = m_cont | ($countones(client_active) > 1);
            n_ovr  = frame_start && m_busy;
            n_tout = m_tout | to;
            n_busy = m_busy;
            if (frame_start && !m_busy) begin
                q.delete();
                for (int i = 0; i < N; i++) if (client_req[i]) q.push_back(i);
                n_busy = 1;
                if (q.size() == 0) fut_fd = cyc + 2;
                else fut_draw = cyc + 2;
            end
            if (rel) begin
                void'(q.pop_front());
                n_owner = -1;
                if (q.size() == 0) fut_fd = cyc + 3;
                else fut_draw = cyc + 3;
            end
            if (m_fd) n_busy = 0;
            n_draw = (fut_draw == cyc + 1 && q.size() > 0) ? q[0] : -1;
            if (n_draw >= 0) begin
                n_owner  = n_draw;
                n_cur    = n_draw;
                m_launch = cyc + 1;
            end
            n_fd = (fut_fd == cyc + 1);
            m_draw = n_draw; m_owner = n_owner; m_cur = n_cur;
            m_busy = n_busy; m_fd = n_fd; m_ovr = n_ovr;
            m_cont = n_cont; m_tout = n_tout;
        end
    end

    // Advance one cycle and drive inputs; clients answer draw after their delay
    task automatic tick(input logic rst_i, input logic fs, input logic [N-1:0] req,
                        input logic [N-1:0] act, input logic [N-1:0] xdone);
        logic [N-1:0] d;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (client_draw[i]) begin
                if (dly_mode[i] == 0) done_at[i] = -1;
                else if (dly_mode[i] < 0) done_at[i] = cyc + int'($urandom_range(1, 20));
                else done_at[i] = cyc + dly_mode[i];
            end
        end
        d = xdone;
        for (int i = 0; i < N; i++) if (done_at[i] == cyc) d[i] = 1'b1;
        if (rst_i) for (int i = 0; i < N; i++) done_at[i] = -1;
        reset         = rst_i;
        frame_start   = fs;
        client_req    = req;
        client_active = act;
        client_done   = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_log();
        for (int i = 0; i < N; i++) draw_cyc[i] = -1;
        fd_cyc = -1; draws_seen = 0; grants_seen = 0; ovr_seen = 0;
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < N; i++) dly_mode[i] = v;
    endtask

    initial begin
        int s;
        logic [N-1:0] act, xd;
        int a;
        reset = 1'b1; frame_start = 1'b0; client_req = '0;
        client_active = '0; client_done = '0;
        for (int i = 0; i < N; i++) done_at[i] = -1;
        set_dly(10);
        clear_log();

        // cycle 1 reset, cycles 2..4 idle, empty-mask frame_start at cycle 5
        tick(1'b1, 1'b0, '0, '0, '0);
        idle(3);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cur", 32'(cur_client), 32'd0);
        clear_log();
        tick(1'b0, 1'b1, 4'b0000, '0, '0);
        idle(6);
        chk("empty_fd_cycle", 32'(fd_cyc), 32'd7);
        chk("empty_no_draw", 32'(draws_seen), 32'd0);
        chk("empty_no_grant", 32'(grants_seen), 32'd0);

        // mask 0101, done 10 cycles after each draw
        clear_log();
        tick(1'b0, 1'b1, 4'b0101, '0, '0);
        s = cyc;
        idle(35);
        chk("seq_draw0", 32'(draw_cyc[0]), 32'(s + 2));
        chk("seq_draw2", 32'(draw_cyc[2]), 32'(s + 15));
        chk("seq_fd", 32'(fd_cyc), 32'(s + 28));
        chk("seq_draw_count", 32'(draws_seen), 32'd2);

        // same pass with a second frame_start during WAIT_DONE
        clear_log();
        tick(1'b0, 1'b1, 4'b0101, '0, '0);
        s = cyc;
        idle(5);
        tick(1'b0, 1'b1, 4'b1111, '0, '0);
        idle(30);
        chk("ovr_count", 32'(ovr_seen), 32'd1);
        chk("ovr_draw2", 32'(draw_cyc[2]), 32'(s + 15));
        chk("ovr_fd", 32'(fd_cyc), 32'(s + 28));
        chk("ovr_draw_count", 32'(draws_seen), 32'd2);

        // two actives for one cycle: sticky contention
        tick(1'b0, 1'b0, '0, 4'b0011, '0);
        tick(1'b0, 1'b0, '0, '0, '0);
        chk("cont_rise", 32'(contention_err), 32'd1);
        idle(5);
        chk("cont_sticky", 32'(contention_err), 32'd1);

        // reset while client 0 is in WAIT_DONE
        tick(1'b0, 1'b1, 4'b1111, '0, '0);
        idle(4);
        chk("pre_reset_grant", 32'(grant), 32'b0001);
        tick(1'b1, 1'b0, '0, '0, '0);
        tick(1'b0, 1'b0, '0, '0, '0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cont", 32'(contention_err), 32'd0);
        chk("rst_tout", 32'(timeout_err), 32'd0);
        idle(15);

`ifdef DRAW_SCHEDULER_WATCHDOG_EN
        // client 1 never answers: abandoned after TB_TO wait cycles
        set_dly(5);
        dly_mode[1] = 0;
        clear_log();
        tick(1'b0, 1'b1, 4'b1010, '0, '0);
        s = cyc;
        idle(40);
        chk("wd_draw1", 32'(draw_cyc[1]), 32'(s + 2));
        chk("wd_draw3", 32'(draw_cyc[3]), 32'(s + 21));
        chk("wd_tout", 32'(timeout_err), 32'd1);
        tick(1'b1, 1'b0, '0, '0, '0);
`endif

        // randomized traffic
        set_dly(-1);
        tick(1'b1, 1'b0, '0, '0, '0);
        for (int k = 0; k < 4000; k++) begin
            a   = int'($urandom_range(0, N));
            act = (a < N) ? onehot(a) : '0;
            if ($urandom_range(0, 399) == 0) act = 4'b0110;
            xd  = ($urandom_range(0, 15) == 0) ? onehot(int'($urandom_range(0, N - 1))) : '0;
            tick($urandom_range(0, 499) == 0,
                 $urandom_range(0, 11) == 0,
                 N'($urandom_range(0, 15)),
                 act, xd);
        end
        idle(3);

`ifndef DRAW_SCHEDULER_WATCHDOG_EN
        chk("no_watchdog_tout", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
